// File: rtl/mem_seq_if.sv
// Command, RAM and read-return signals of mem_seq, with DUT-side (slave) and environment-side (master) modports.
// acc_count/err_count are present only when MEM_SEQ_STATS_EN is defined.
interface mem_seq_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          L;
   logic          R;
   logic          S;
   logic          W;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_re;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] rdata;
   logic          rdata_valid;
   logic          rdata_tag;
   logic          err;
`ifdef MEM_SEQ_STATS_EN
   logic [15:0]   acc_count;
   logic [7:0]    err_count;
`endif

   modport slave (
      input  L, R, S, W, addr, wdata, mem_rdata,
      output busy, mem_addr, mem_wdata, mem_re, mem_we, rdata, rdata_valid, rdata_tag, err
`ifdef MEM_SEQ_STATS_EN
      , output acc_count, err_count
`endif
   );

   modport master (
      output L, R, S, W, addr, wdata, mem_rdata,
      input  busy, mem_addr, mem_wdata, mem_re, mem_we, rdata, rdata_valid, rdata_tag, err
`ifdef MEM_SEQ_STATS_EN
      , input acc_count, err_count
`endif
   );
endinterface

// File: rtl/mem_seq.sv
// Memory access sequencer: 2-entry command queue feeding single RAM accesses with WAIT wait states.
// Optional MEM_SEQ_STATS_EN adds an access counter (wrapping) and an error counter (saturating).
module mem_seq #(
   parameter int AW   = 8,
   parameter int DW   = 8,
   parameter int WAIT = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   mem_seq_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   typedef struct packed {
      logic          wr;
      logic          tag;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   state_t        state_q, state_d;
   cmd_t          fifo_q [2];
   cmd_t          new_cmd, head;
   logic          wp_q, rp_q;
   logic [1:0]    cnt_q, cnt_d;
   logic          busy_q, err_q;
   logic [3:0]    wcnt_q, wcnt_d;
   logic          op_q, tag_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, rdata_q;
   logic [2:0]    nstb;
   logic          push, pop, reject, capture;

   // A strobe seen while busy is dropped even if the queue drains on the same edge.
   always_comb begin
      nstb          = 3'(bus.L) + 3'(bus.R) + 3'(bus.S) + 3'(bus.W);
      push          = (nstb == 3'd1) && !busy_q;
      reject        = (nstb > 3'd1) || ((nstb != 3'd0) && busy_q);
      new_cmd.wr    = bus.S | bus.W;
      new_cmd.tag   = bus.R | bus.W;
      new_cmd.addr  = bus.addr;
      new_cmd.wdata = bus.wdata;
   end

   assign head  = fifo_q[rp_q];
   assign cnt_d = cnt_q + 2'(push) - 2'(pop);

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      pop     = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cnt_q != 2'd0) begin
               pop     = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wcnt_d = 4'(WAIT);
            if (op_q)           state_d = ST_IDLE;
            else if (WAIT == 0) state_d = ST_DONE;
            else                state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q <= 4'd1) state_d = ST_DONE;
         end
         ST_DONE: begin
            capture = 1'b1;
            if (cnt_q != 2'd0) begin
               pop     = 1'b1;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Queue storage carries no control meaning, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wp_q] <= new_cmd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wp_q    <= 1'b0;
         rp_q    <= 1'b0;
         cnt_q   <= 2'd0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         wcnt_q  <= 4'd0;
         op_q    <= 1'b0;
         tag_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (cnt_d == 2'd2);
         err_q   <= reject;
         wcnt_q  <= wcnt_d;
         if (push) wp_q <= ~wp_q;
         if (pop) begin
            rp_q   <= ~rp_q;
            op_q   <= head.wr;
            tag_q  <= head.tag;
            addr_q <= head.addr;
            if (head.wr) wdata_q <= head.wdata;
         end
         if (capture) rdata_q <= bus.mem_rdata;
      end
   end

   // Read data passes straight through during DONE and is held afterwards.
   assign bus.busy        = busy_q;
   assign bus.err         = err_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.mem_re      = (state_q == ST_ISSUE) && !op_q;
   assign bus.mem_we      = (state_q == ST_ISSUE) && op_q;
   assign bus.rdata_valid = (state_q == ST_DONE);
   assign bus.rdata       = (state_q == ST_DONE) ? bus.mem_rdata : rdata_q;
   assign bus.rdata_tag   = tag_q;

`ifdef MEM_SEQ_STATS_EN
   logic [15:0] acc_count_q;
   logic [7:0]  err_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_count_q <= 16'd0;
         err_count_q <= 8'd0;
      end else begin
         acc_count_q <= acc_count_q + 16'(state_q == ST_ISSUE);
         if (reject && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
      end
   end

   assign bus.acc_count = acc_count_q;
   assign bus.err_count = err_count_q;
`endif

endmodule
